// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard unit for an in-order pipeline.
// It keeps a shadow of the destination info for the stages from EX onward
// and the EX source operands. It also counts stall cycles and forwarding cycles.
// Ports:
//   clk_i, rst_i            rising-edge clock, synchronous active-high reset
//   id_valid_i              an instruction is present in ID
//   id_src_addr_i           ID source addresses; source j sits at [j*ADDR_W +: ADDR_W]
//   id_src_used_i           per-source read enable
//   id_rd_addr_i            ID destination register
//   id_regwrite_i           the ID instruction writes rd
//   id_memread_i            the ID instruction is a load
//   flush_i                 kill the instruction entering EX
//   stall_o                 hold IF/ID and insert a bubble (combinational)
//   ex_fwd_sel_o            per EX source forward select; 0 = register file, k = stage k
//   stall_cnt_o, fwd_cnt_o  saturating statistic counters
module forward_hazard_unit #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_SRC  = 2,
   parameter int unsigned DEPTH    = 3,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 16,
   localparam int unsigned SEL_W   = $clog2(DEPTH)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        id_valid_i,
   input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr_i,
   input  logic [NUM_SRC-1:0]          id_src_used_i,
   input  logic [ADDR_W-1:0]           id_rd_addr_i,
   input  logic                        id_regwrite_i,
   input  logic                        id_memread_i,
   input  logic                        flush_i,
   output logic                        stall_o,
   output logic [NUM_SRC*SEL_W-1:0]    ex_fwd_sel_o,
   output logic [CNT_W-1:0]            stall_cnt_o,
   output logic [CNT_W-1:0]            fwd_cnt_o
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] rd;
      logic              regwrite;
      logic              memread;
   } entry_t;

   entry_t [DEPTH-1:0]              pipe_q, pipe_d;
   logic   [NUM_SRC-1:0][ADDR_W-1:0] ex_addr_q, ex_addr_d;
   logic   [NUM_SRC-1:0]            ex_used_q, ex_used_d;
   logic   [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;
   logic   [CNT_W-1:0]              fwd_cnt_q, fwd_cnt_d;

   logic                            stall_c;
   logic                            issue_c;
   logic   [NUM_SRC*SEL_W-1:0]      fwd_sel_c;

   // An entry produces a value for address a. Register 0 never matches.
   function automatic logic is_writer(input entry_t e, input logic [ADDR_W-1:0] a);
      return e.valid && e.regwrite && (e.rd == a) && (a != '0);
   endfunction

   // The youngest writer decides the hazard, so an older load that is shadowed by a
   // younger ALU write to the same register does not stall. The scan runs from the
   // oldest stage to the youngest, so the youngest writer is the last to assign.
   function automatic logic load_use(input entry_t [DEPTH-1:0] p,
                                     input logic [ADDR_W-1:0] a);
      logic hz;
      hz = 1'b0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         if (is_writer(p[k], a)) hz = p[k].memread && (k < int'(LOAD_LAT));
      end
      return hz;
   endfunction

   // Load-use detection against the ID operands. A flush suppresses the stall.
   always_comb begin
      stall_c = 1'b0;
      if (id_valid_i && !flush_i) begin
         for (int j = 0; j < int'(NUM_SRC); j++) begin
            if (id_src_used_i[j] && load_use(pipe_q, id_src_addr_i[j*ADDR_W +: ADDR_W]))
               stall_c = 1'b1;
         end
      end
   end

   // Forward select: the nearest writer past EX wins. The scan goes downward so the
   // smallest stage index is the last to assign.
   always_comb begin
      fwd_sel_c = '0;
      for (int j = 0; j < int'(NUM_SRC); j++) begin
         if (ex_used_q[j]) begin
            for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
               if (is_writer(pipe_q[k], ex_addr_q[j]))
                  fwd_sel_c[j*SEL_W +: SEL_W] = SEL_W'(k);
            end
         end
      end
   end

   // Next state: the shadow pipeline shifts every cycle and a bubble enters on stall or flush.
   always_comb begin
      issue_c            = id_valid_i && !stall_c && !flush_i;
      pipe_d[0].valid    = issue_c;
      pipe_d[0].rd       = id_rd_addr_i;
      pipe_d[0].regwrite = id_regwrite_i;
      pipe_d[0].memread  = id_memread_i;
      for (int k = 1; k < int'(DEPTH); k++) pipe_d[k] = pipe_q[k-1];
      for (int j = 0; j < int'(NUM_SRC); j++) ex_addr_d[j] = id_src_addr_i[j*ADDR_W +: ADDR_W];
      ex_used_d   = issue_c ? id_src_used_i : '0;
      stall_cnt_d = stall_cnt_q;
      if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      fwd_cnt_d   = fwd_cnt_q;
      if ((|fwd_sel_c) && (fwd_cnt_q != '1)) fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe_q      <= '0;
         ex_addr_q   <= '0;
         ex_used_q   <= '0;
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         pipe_q      <= pipe_d;
         ex_addr_q   <= ex_addr_d;
         ex_used_q   <= ex_used_d;
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_o      = stall_c;
   assign ex_fwd_sel_o = fwd_sel_c;
   assign stall_cnt_o  = stall_cnt_q;
   assign fwd_cnt_o    = fwd_cnt_q;

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, source operands per instruction.
REQ-003 SHALL have parameter DEPTH, default 3, tracked stages; stage 0 = EX, stage 1 = EX/MEM, stage k = k stages past EX; legal range 3..8.
REQ-004 SHALL have parameter LOAD_LAT, default 1, stages after EX before load data is forwardable; legal range 1..DEPTH-2.
REQ-005 SHALL have parameter CNT_W, default 16, statistic counter width; SEL_W = clog2(DEPTH) is derived.
REQ-006 SHALL have port clk_i, input, 1, rising-edge clock.
REQ-007 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-008 SHALL have port id_valid_i, input, 1, valid instruction in ID.
REQ-009 SHALL have port id_src_addr_i, input, NUM_SRC*ADDR_W, ID source addresses; source j at bits [j*ADDR_W +: ADDR_W].
REQ-010 SHALL have port id_src_used_i, input, NUM_SRC, per-source read enable.
REQ-011 SHALL have port id_rd_addr_i, input, ADDR_W, ID destination.
REQ-012 SHALL have port id_regwrite_i, input, 1, ID instruction writes rd.
REQ-013 SHALL have port id_memread_i, input, 1, ID instruction is a load.
REQ-014 SHALL have port flush_i, input, 1, kill the instruction entering EX.
REQ-015 SHALL have port stall_o, output, 1, hold IF/ID and insert a bubble.
REQ-016 SHALL have port ex_fwd_sel_o, output, NUM_SRC*SEL_W, per EX source forward select.
REQ-017 SHALL have ports stall_cnt_o and fwd_cnt_o, output, CNT_W each, statistic counters.

Function
REQ-018 SHALL hold a DEPTH-entry shadow pipeline; each entry = {valid, rd, regwrite, memread}; plus registered EX sources {addr, used} per source.
REQ-019 SHALL shift every cycle: entry[k] <= entry[k-1] for k = 1..DEPTH-1, unconditionally.
REQ-020 SHALL load entry[0] and the EX sources from ID when id_valid_i=1, stall_o=0 and flush_i=0; otherwise entry[0].valid <= 0 and all EX used bits <= 0.
REQ-021 SHALL define matching writer for an address A: entry valid=1, regwrite=1, rd == A, A != 0.
REQ-022 SHALL drive ex_fwd_sel_o source j = smallest k in 1..DEPTH-1 with matching writer for EX source j; 0 when source unused or no match; combinational from registered state only.
REQ-023 SHALL encode select values as stage index (1 = EX/MEM, 2 = MEM/WB, ...); value 0 = register file.
REQ-024 SHALL assert stall_o when id_valid_i=1, flush_i=0 and, for any used ID source, the youngest matching writer in stages 0..DEPTH-1 is a load at stage k < LOAD_LAT.
REQ-025 SHALL NOT stall when a younger non-load writer shadows an older load to the same register.
REQ-026 SHALL force stall_o=0 while flush_i=1; flush wins over stall.
REQ-027 SHALL increment stall_cnt_o each cycle stall_o=1, saturating at all-ones.
REQ-028 SHALL increment fwd_cnt_o each cycle any ex_fwd_sel_o field is nonzero (by 1, not per source), saturating at all-ones.
REQ-029 SHALL compare address 0 as never forwarding and never stalling.

Reset
REQ-030 SHALL, on rst_i=1 at a clock edge, clear all entry valid bits, all EX used bits and both counters; stall_o and ex_fwd_sel_o are then 0.
REQ-031 SHALL give reset priority over all inputs, including mid-stall and mid-flush.

Verification
REQ-032 SHALL cover: add r3 issued, next cycle reader src0=r3 issued -> when reader is in EX, sel0=1, fwd_cnt_o=1.
REQ-033 SHALL cover: write r3, unrelated, reader r3 -> reader in EX sees sel0=2; sel1=0 with src1 unused.
REQ-034 SHALL cover (LOAD_LAT=1): lw r4 in EX, reader r4 in ID -> stall_o=1 exactly one cycle, bubble in stage 0, reader then in EX with sel0=2, stall_cnt_o=1.
REQ-035 SHALL cover: writers to r5 in stages 1 and 2 -> sel=1; writer to r0 -> sel=0, no stall.
REQ-036 SHALL cover: load-use with flush_i=1 same cycle -> stall_o=0, stage 0 bubble; stall_cnt_o saturation at 0xFFFF; rst_i mid-stall -> all outputs 0 next cycle.
